imu_cmd_seq: RTL and testbench

- Command sequencer that sits directly upstream of the SPI monarch.
- After reset it writes the IMU configuration registers, then services data-ready interrupts by reading the yaw-rate low/high bytes.
- Drives the monarch's wrt/cmd, consumes its done/rd_data, and presents an assembled 16-bit yaw rate with a one-cycle valid strobe to the downstream integrator.

---
 rtl/imu_cmd_seq.sv | 134 +++++++++++++
 tb/tb_imu_cmd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_cmd_seq.sv
// Command sequencer in front of the SPI monarch: configures the IMU after power-up,
// then turns data-ready interrupts into yaw-rate low/high reads and assembles the result.
module imu_cmd_seq #(
  parameter int TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done,
  output logic        missed
);

  localparam logic [2:0] INIT_WAIT = 3'd0;
  localparam logic [2:0] INIT1     = 3'd1;
  localparam logic [2:0] INIT2     = 3'd2;
  localparam logic [2:0] INIT3     = 3'd3;
  localparam logic [2:0] IDLE      = 3'd4;
  localparam logic [2:0] RDL       = 3'd5;
  localparam logic [2:0] RDH       = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             int_s1_q, int_s2_q, int_s3_q;
  logic             done_ff_q;
  logic             pend_q, pend_d;
  logic             missed_q, missed_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       yl_q, yl_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      yaw_q, yaw_d;
  logic             vld_q, vld_d;
  logic             int_edge, done_edge, consume;
  logic             unused_rd_hi;

  assign int_edge  = int_s2_q & ~int_s3_q;
  // Only the rising edge counts: done stays high from the previous transaction.
  assign done_edge = done & ~done_ff_q;
  // Upper byte of rd_data is whatever the IMU clocked out during the address phase.
  assign unused_rd_hi = ^rd_data[15:8];

  always_comb begin
    state_d     = state_q;
    wrt         = 1'b0;
    cmd_d       = cmd_q;
    yl_d        = yl_q;
    yaw_d       = yaw_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    consume     = 1'b0;
    tmr_d       = (state_q == INIT_WAIT) ? tmr_q + 1'b1 : tmr_q;
    case (state_q)
      INIT_WAIT: if (&tmr_q) begin
        state_d = INIT1; wrt = 1'b1; cmd_d = 16'h0D02;
      end
      INIT1: if (done_edge) begin
        state_d = INIT2; wrt = 1'b1; cmd_d = 16'h1160;
      end
      INIT2: if (done_edge) begin
        state_d = INIT3; wrt = 1'b1; cmd_d = 16'h1440;
      end
      INIT3: if (done_edge) begin
        state_d = IDLE; init_done_d = 1'b1;
      end
      IDLE: if (pend_q) begin
        state_d = RDL; wrt = 1'b1; cmd_d = 16'hA600; consume = 1'b1;
      end
      RDL: if (done_edge) begin
        state_d = RDH; wrt = 1'b1; cmd_d = 16'hA700; yl_d = rd_data[7:0];
      end
      RDH: if (done_edge) begin
        state_d = IDLE; yaw_d = {rd_data[7:0], yl_q}; vld_d = 1'b1;
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  // A new INT edge beats the IDLE consume in the same cycle, so nothing is lost there.
  always_comb begin
    pend_d   = pend_q;
    missed_d = missed_q;
    if (int_edge && init_done_q) begin
      pend_d = 1'b1;
      if (pend_q && !consume) missed_d = 1'b1;
    end else if (consume) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_WAIT;
      tmr_q       <= '0;
      int_s1_q    <= 1'b0;
      int_s2_q    <= 1'b0;
      int_s3_q    <= 1'b0;
      done_ff_q   <= 1'b0;
      pend_q      <= 1'b0;
      missed_q    <= 1'b0;
      init_done_q <= 1'b0;
      yl_q        <= 8'h00;
      cmd_q       <= 16'h0000;
      yaw_q       <= 16'h0000;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      int_s1_q    <= INT;
      int_s2_q    <= int_s1_q;
      int_s3_q    <= int_s2_q;
      done_ff_q   <= done;
      pend_q      <= pend_d;
      missed_q    <= missed_d;
      init_done_q <= init_done_d;
      yl_q        <= yl_d;
      cmd_q       <= cmd_d;
      yaw_q       <= yaw_d;
      vld_q       <= vld_d;
    end
  end

  // New command is presented in the wrt cycle itself and held from cmd_q afterwards.
  assign cmd       = cmd_d;
  assign yaw_rt    = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_imu_cmd_seq.sv
// Scoreboard bench for imu_cmd_seq: a behavioural SPI monarch answers every wrt,
// expected commands/yaw values are queued by stimulus and checked by a monitor.
module tb_imu_cmd_seq;
  logic        clk = 1'b0, rst_n = 1'b0, INT = 1'b0, done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, vld, init_done, missed;
  logic [15:0] cmd, yaw_rt;

  imu_cmd_seq #(.TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld),
    .init_done(init_done), .missed(missed)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wrt_cnt = 0, vld_cnt = 0;
  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_yaw_q[$];
  logic [7:0]  data_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes wrt or vld.
  logic pw = 1'b0, pv = 1'b0, pd = 1'b0, outst = 1'b0;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pw = 1'b0; pv = 1'b0; pd = done; outst = 1'b0;
      end else begin
        if (done && !pd) outst = 1'b0;
        if (wrt) begin
          wrt_cnt++;
          chk("wrt_back_to_back", 32'(pw), 32'd0);
          chk("wrt_while_outstanding", 32'(outst), 32'd0);
          if (exp_cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wrt: got cmd %h expected no command", cmd);
          end else begin
            e = exp_cmd_q.pop_front();
            chk("cmd", 32'(cmd), 32'(e));
          end
          outst = 1'b1;
        end
        if (vld) begin
          vld_cnt++;
          chk("vld_width", 32'(pv), 32'd0);
          if (exp_yaw_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_vld: got yaw %h expected no result", yaw_rt);
          end else begin
            e = exp_yaw_q.pop_front();
            chk("yaw_rt", 32'(yaw_rt), 32'(e));
          end
        end
        pw = wrt; pv = vld; pd = done;
      end
    end
  end

  // Monarch model: done drops after an optional stale hold, rises after a latency.
  // Transactions 0..2 are config writes; after that they alternate low/high yaw bytes.
  int n = 0;
  initial begin
    int hold, lat;
    bit ab;
    logic [7:0] b, junk, lo;
    lo = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0; done = 1'b0;
      end else if (wrt) begin
        hold = $urandom_range(0, 3);
        lat  = $urandom_range(8, 30);
        ab   = 1'b0;
        for (int i = 0; i <= hold && !ab; i++) begin
          @(posedge clk); #1;
          if (!rst_n) ab = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < lat && !ab; i++) begin
          @(posedge clk); #1;
          if (!rst_n) ab = 1'b1;
        end
        if (ab) begin
          n = 0;
        end else begin
          if (data_q.size() > 0) b = data_q.pop_front();
          else b = 8'($urandom);
          junk = 8'($urandom);
          rd_data = {junk, b};
          if (n >= 3) begin
            if (((n - 3) % 2) == 0) lo = b;
            else exp_yaw_q.push_back({b, lo});
          end
          n++;
          done = 1'b1;
        end
      end
    end
  end

  task automatic push_init();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1160);
    exp_cmd_q.push_back(16'h1440);
  endtask

  task automatic push_read();
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wrt"}, 32'(wrt), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_yaw"}, 32'(yaw_rt), 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_missed"}, 32'(missed), 32'd0);
  endtask

  // Counts cycles after reset release until the first wrt; optionally pulses INT pre-init.
  task automatic check_first_wrt(input bit pulse_int);
    int first = -1, cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (pulse_int && i == 3) INT = 1'b1;
      if (pulse_int && i == 5) INT = 1'b0;
      if (wrt) begin
        cnt++;
        if (first < 0) begin
          first = i;
          chk("first_cmd", 32'(cmd), 32'h0D02);
        end
      end
    end
    chk("first_wrt_cycle", first, 15);
    chk("wrt_count_in_wait", cnt, 1);
  endtask

  task automatic wait_init();
    int k = 0;
    while (!init_done && k < 1000) begin @(posedge clk); #1; k++; end
    chk("init_done", 32'(init_done), 32'd1);
  endtask

  task automatic wait_vld(input int target);
    int k = 0;
    while (vld_cnt < target && k < 500) begin @(posedge clk); #1; k++; end
    chk("vld_arrived", 32'(vld_cnt >= target), 32'd1);
  endtask

  task automatic wait_wrt(input int target);
    int k = 0;
    while (wrt_cnt < target && k < 500) begin @(posedge clk); #1; k++; end
    chk("wrt_arrived", 32'(wrt_cnt >= target), 32'd1);
  endtask

  task automatic pulse_int(input int w);
    @(posedge clk); #1 INT = 1'b1;
    repeat (w) @(posedge clk);
    #1 INT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, v;
    #12;
    chk_reset_outputs("reset");
    push_init();
    @(posedge clk); #1 rst_n = 1'b1;
    check_first_wrt(1'b1);
    wait_init();
    chk("missed_after_init", 32'(missed), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_init_int_ignored", wrt_cnt, 3);

    // Directed read: low byte CD, high byte AB.
    data_q.push_back(8'hCD);
    data_q.push_back(8'hAB);
    push_read();
    v = vld_cnt;
    pulse_int(2);
    wait_vld(v + 1);
    chk("yaw_directed", 32'(yaw_rt), 32'hABCD);

    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 10)) @(posedge clk);
      push_read();
      v = vld_cnt;
      pulse_int($urandom_range(1, 4));
      wait_vld(v + 1);
    end
    chk("missed_single_ints", 32'(missed), 32'd0);

    // Three extra INT edges while a read pair is in flight: one more pair, missed set.
    push_read(); push_read();
    w = wrt_cnt; v = vld_cnt;
    pulse_int(2);
    wait_wrt(w + 1);
    for (int p = 0; p < 3; p++) pulse_int(2);
    wait_vld(v + 2);
    repeat (60) @(posedge clk);
    #1;
    chk("missed_burst", 32'(missed), 32'd1);
    chk("burst_wrt_count", wrt_cnt, w + 4);

    // Reset while the high-byte read is outstanding.
    push_read();
    w = wrt_cnt;
    pulse_int(2);
    wait_wrt(w + 2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_cmd_q.delete();
    exp_yaw_q.delete();
    push_init();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_first_wrt(1'b0);
    wait_init();
    push_read();
    v = vld_cnt;
    pulse_int(1);
    wait_vld(v + 1);
    repeat (10) @(posedge clk);
    #1;
    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("yaw_queue_drained", exp_yaw_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
